vga_timing: RTL and testbench

//  Generates the display timing carried on vga_if: hcount/vcount, blanking and sync for
//  1024x768@60 (65 MHz pixel clock). Head of the video pipeline; every draw_* stage consumes
//  its vga_if.out. Also emits line/frame strobes and a frame counter for game-logic pacing.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_if.sv | 14 +
 rtl/vga_axis_counter.sv | 38 +++
 rtl/vga_timing.sv | 96 +++++++++
 tb/tb_vga_timing.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Default 1024x768@60 display timing (65 MHz pixel clock) and the shared count type.
package vga_pkg;

    localparam int H_ACT  = 1024;
    localparam int H_FP   = 24;
    localparam int H_SYNC = 136;
    localparam int H_BP   = 160;
    localparam int H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;

    localparam int V_ACT  = 768;
    localparam int V_FP   = 3;
    localparam int V_SYNC = 6;
    localparam int V_BP   = 29;
    localparam int V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;

    localparam int HS_START = H_ACT + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACT + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic HS_POL = 1'b0;
    localparam logic VS_POL = 1'b0;

    localparam int COUNT_W = 11;
    typedef logic [COUNT_W-1:0] vga_count_t;

    // Half-open window test [lo, hi) on unsigned counts.
    function automatic logic in_window(vga_count_t v, vga_count_t lo, vga_count_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_if.sv
// Video timing bundle passed down the draw pipeline.
interface vga_if;
    import vga_pkg::vga_count_t;

    vga_count_t hcount;
    vga_count_t vcount;
    logic       hblnk;
    logic       vblnk;
    logic       hsync;
    logic       vsync;

    modport out (output hcount, vcount, hblnk, vblnk, hsync, vsync);
    modport in  (input  hcount, vcount, hblnk, vblnk, hsync, vsync);
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: counts 0..TOT-1 while enabled and flags the last position.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOT = H_TOT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output vga_count_t count,
    output vga_count_t count_nxt,
    output logic       wrap
);

    localparam vga_count_t LAST = vga_count_t'(TOT - 1);

    assign wrap = (count == LAST);

    // count_nxt is the value the register holds after this edge, so the top can
    // decode blanking/sync from it and stay aligned with the count.
    always_comb begin
        // NOTE: default first so no path leaves count_nxt unassigned (no latch).
        count_nxt = count;
        if (en) begin
            count_nxt = wrap ? '0 : count + vga_count_t'(1);
        end
    end

    // NOTE: non-blocking for state so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// Display timing generator: counters, registered blank/sync decode, line/frame strobes
// and a free-running frame counter for game-logic pacing.
module vga_timing
    import vga_pkg::vga_count_t, vga_pkg::COUNT_W, vga_pkg::in_window;
#(
    parameter int   H_ACT  = vga_pkg::H_ACT,
    parameter int   H_FP   = vga_pkg::H_FP,
    parameter int   H_SYNC = vga_pkg::H_SYNC,
    parameter int   H_BP   = vga_pkg::H_BP,
    parameter int   V_ACT  = vga_pkg::V_ACT,
    parameter int   V_FP   = vga_pkg::V_FP,
    parameter int   V_SYNC = vga_pkg::V_SYNC,
    parameter int   V_BP   = vga_pkg::V_BP,
    parameter logic HS_POL = vga_pkg::HS_POL,
    parameter logic VS_POL = vga_pkg::VS_POL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    vga_if.out          vout,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

    localparam vga_count_t H_ACT_C    = vga_count_t'(H_ACT);
    localparam vga_count_t V_ACT_C    = vga_count_t'(V_ACT);
    localparam vga_count_t HS_START_C = vga_count_t'(H_ACT + H_FP);
    localparam vga_count_t HS_END_C   = vga_count_t'(H_ACT + H_FP + H_SYNC);
    localparam vga_count_t VS_START_C = vga_count_t'(V_ACT + V_FP);
    localparam vga_count_t VS_END_C   = vga_count_t'(V_ACT + V_FP + V_SYNC);

    if (H_TOT > (1 << COUNT_W) || V_TOT > (1 << COUNT_W)) begin : g_size_check
        $error("vga_timing: H_TOT/V_TOT exceed the 11-bit counter range");
    end

    vga_count_t h_count, h_nxt, v_count, v_nxt;
    logic       h_wrap, v_wrap;
    logic       hblnk_q, vblnk_q, hsync_q, vsync_q;

    vga_axis_counter #(.TOT(H_TOT)) u_h_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (pix_en),
        .count     (h_count),
        .count_nxt (h_nxt),
        .wrap      (h_wrap)
    );

    vga_axis_counter #(.TOT(V_TOT)) u_v_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (pix_en && h_wrap),
        .count     (v_count),
        .count_nxt (v_nxt),
        .wrap      (v_wrap)
    );

    // Strobes default low each cycle, so a frozen pipeline never repeats one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hblnk_q     <= 1'b0;
            vblnk_q     <= 1'b0;
            hsync_q     <= ~HS_POL;
            vsync_q     <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                hblnk_q     <= (h_nxt >= H_ACT_C);
                vblnk_q     <= (v_nxt >= V_ACT_C);
                hsync_q     <= in_window(h_nxt, HS_START_C, HS_END_C) ? HS_POL : ~HS_POL;
                vsync_q     <= in_window(v_nxt, VS_START_C, VS_END_C) ? VS_POL : ~VS_POL;
                line_start  <= (h_nxt == '0);
                frame_start <= (h_nxt == '0) && (v_nxt == '0);
                if (h_wrap && v_wrap) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end
        end
    end

    assign vout.hcount = h_count;
    assign vout.vcount = v_count;
    assign vout.hblnk  = hblnk_q;
    assign vout.vblnk  = vblnk_q;
    assign vout.hsync  = hsync_q;
    assign vout.vsync  = vsync_q;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench: a full-size 1024x768 instance plus a tiny-raster instance so that
// whole frames, freezes and frame counting are exercised within a short run.
module tb_vga_timing;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic pix_en = 1'b0;

    always #5 clk = ~clk;

    vga_if vif_d ();
    vga_if vif_s ();
    logic        ls_d, fs_d, ls_s, fs_s;
    logic [15:0] fc_d, fc_s;

    vga_timing dut_d (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .vout        (vif_d),
        .line_start  (ls_d),
        .frame_start (fs_d),
        .frame_cnt   (fc_d)
    );

    vga_timing #(
        .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) dut_s (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .vout        (vif_s),
        .line_start  (ls_s),
        .frame_start (fs_s),
        .frame_cnt   (fc_s)
    );

    typedef struct {
        int h_act, h_fp, h_sync, h_bp;
        int v_act, v_fp, v_sync, v_bp;
        bit hpol, vpol;
    } cfg_t;

    typedef struct {
        int hc, vc;
        bit hb, vb, hs, vs, ls, fs;
        int fc;
    } obs_t;

    cfg_t   cfg_d = '{1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0};
    cfg_t   cfg_s = '{8, 2, 3, 3, 4, 1, 2, 2, 1'b1, 1'b0};
    obs_t   exp_d[$];
    obs_t   exp_s[$];
    longint adv = 0;
    int     n_cmp = 0;
    int     n_bad = 0;

    // Reference: the raster position is simply the number of enabled pixel advances
    // since reset, folded into (line, pixel) coordinates.
    function automatic obs_t model(cfg_t c, longint a, bit stepped);
        obs_t   m;
        longint ht  = c.h_act + c.h_fp + c.h_sync + c.h_bp;
        longint vt  = c.v_act + c.v_fp + c.v_sync + c.v_bp;
        longint pos = a % (ht * vt);
        m.hc = int'(pos % ht);
        m.vc = int'(pos / ht);
        m.hb = (m.hc >= c.h_act);
        m.vb = (m.vc >= c.v_act);
        m.hs = (m.hc >= c.h_act + c.h_fp && m.hc < c.h_act + c.h_fp + c.h_sync) ? c.hpol : !c.hpol;
        m.vs = (m.vc >= c.v_act + c.v_fp && m.vc < c.v_act + c.v_fp + c.v_sync) ? c.vpol : !c.vpol;
        m.ls = stepped && (m.hc == 0);
        m.fs = stepped && (pos == 0);
        m.fc = int'((a / (ht * vt)) % 65536);
        return m;
    endfunction

    function automatic obs_t sample_d();
        obs_t o;
        o = '{int'(vif_d.hcount), int'(vif_d.vcount), vif_d.hblnk, vif_d.vblnk,
              vif_d.hsync, vif_d.vsync, ls_d, fs_d, int'(fc_d)};
        return o;
    endfunction

    function automatic obs_t sample_s();
        obs_t o;
        o = '{int'(vif_s.hcount), int'(vif_s.vcount), vif_s.hblnk, vif_s.vblnk,
              vif_s.hsync, vif_s.vsync, ls_s, fs_s, int'(fc_s)};
        return o;
    endfunction

    task automatic check(string name, obs_t got, obs_t want);
        bit ok;
        ok = (got.hc == want.hc) && (got.vc == want.vc) && (got.hb == want.hb) &&
             (got.vb == want.vb) && (got.hs == want.hs) && (got.vs == want.vs) &&
             (got.ls == want.ls) && (got.fs == want.fs) && (got.fc == want.fc);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s @%0t: got h=%0d v=%0d hb=%0b vb=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d; want h=%0d v=%0d hb=%0b vb=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d",
                     name, $time, got.hc, got.vc, got.hb, got.vb, got.hs, got.vs, got.ls, got.fs, got.fc,
                     want.hc, want.vc, want.hb, want.vb, want.hs, want.vs, want.ls, want.fs, want.fc);
        end
    endtask

    // Drive one cycle's inputs on the falling edge and queue what the next rising
    // edge must produce.
    task automatic step(bit rst_v, bit en_v);
        bit stepped;
        @(negedge clk);
        rst_n  = rst_v;
        pix_en = en_v;
        stepped = 1'b0;
        if (!rst_v) begin
            adv = 0;
        end else if (en_v) begin
            adv++;
            stepped = 1'b1;
        end
        exp_d.push_back(model(cfg_d, adv, stepped));
        exp_s.push_back(model(cfg_s, adv, stepped));
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (exp_d.size() > 0) check("full_raster", sample_d(), exp_d.pop_front());
            if (exp_s.size() > 0) check("tiny_raster", sample_s(), exp_s.pop_front());
        end
    end

    initial begin : stimulus
        repeat (3) step(1'b0, 1'b0);

        // Two full default lines plus change, continuous enable.
        repeat (3000) step(1'b1, 1'b1);

        // Random pauses in the pixel enable.
        repeat (3000) step(1'b1, $urandom_range(0, 3) != 0);

        // Freeze the tiny raster on its last pixel, then let it wrap into a new frame.
        while (adv % 144 != 143) step(1'b1, 1'b1);
        repeat (50) step(1'b1, 1'b0);
        repeat (200) step(1'b1, 1'b1);

        // Asynchronous reset mid-frame must take effect before the next clock edge.
        repeat ($urandom_range(1, 600)) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        #1;
        check("async_reset_full", sample_d(), model(cfg_d, 0, 1'b0));
        check("async_reset_tiny", sample_s(), model(cfg_s, 0, 1'b0));
        step(1'b0, 1'b1);
        repeat (1500) step(1'b1, $urandom_range(0, 7) != 0);

        @(posedge clk);
        #2;
        n_cmp++;
        if (exp_d.size() != 0 || exp_s.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending, want 0/0", exp_d.size(), exp_s.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
